// File: rtl/const_seq_if.sv
// Output stream bundle for const_seq: data beat, index tag, last marker
// and the valid/ready handshake. The sequencer uses the master side and
// the consumer uses the slave side.
interface const_seq_if;
  logic [7:0] o_data;
  logic       o_valid;
  logic       o_ready;
  logic       o_last;
  logic [2:0] o_idx;

  modport master (
    output o_data,
    output o_valid,
    output o_last,
    output o_idx,
    input  o_ready
  );

  modport slave (
    input  o_data,
    input  o_valid,
    input  o_last,
    input  o_idx,
    output o_ready
  );
endinterface

// File: rtl/const_seq.sv
// const_seq: streams a fixed 8-entry byte table over a valid/ready
// interface, repeated for a latched number of passes (0 = run until
// aborted). It pulses done for one cycle after the final beat.
// Optional feature: define CONST_SEQ_CHECKSUM_EN to append a 9th beat
// (8'hE2, reported at index 7) to every pass so that the 8-bit sum of the
// nine beats is zero. That beat then carries o_last instead of index 7.
module const_seq #(
  parameter int PASS_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [PASS_W-1:0] passes,
  const_seq_if.master       bus,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [PASS_W-1:0] ONE = PASS_W'(1);

  state_t            state;
  state_t            state_nxt;
  logic [2:0]        idx;
  logic [PASS_W-1:0] pass_cnt;
  logic [PASS_W-1:0] passes_q;
  logic [7:0]        rom_data;
  logic              accept;
  logic              xfer;
  logic              final_pass;
  logic              last_beat;
`ifdef CONST_SEQ_CHECKSUM_EN
  logic              cks;
`endif

  assign accept     = (state == IDLE) && start && !abort;
  assign xfer       = (state == RUN) && bus.o_ready;
  assign final_pass = (passes_q != '0) && (pass_cnt == passes_q - ONE);

`ifdef CONST_SEQ_CHECKSUM_EN
  assign last_beat = cks && final_pass;
`else
  assign last_beat = (idx == 3'd7) && final_pass;
`endif

  // Fixed beat table addressed by the index counter
  always_comb begin
    rom_data = 8'h00;
    case (idx)
      3'd0: rom_data = 8'h01;
      3'd1: rom_data = 8'h00;
      3'd2: rom_data = 8'h05;
      3'd3: rom_data = 8'h65;
      3'd4: rom_data = 8'h5A;
      3'd5: rom_data = 8'h05;
      3'd6: rom_data = 8'h59;
      3'd7: rom_data = 8'hFB;
    endcase
  end

  // State register; reset lands in IDLE so all decoded outputs drop at once
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and output decode; outputs are only non-zero in RUN/DONE
  always_comb begin
    state_nxt   = state;
    bus.o_valid = 1'b0;
    bus.o_data  = 8'h00;
    bus.o_idx   = 3'd0;
    bus.o_last  = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          state_nxt = RUN;
        end
      end
      RUN: begin
        busy        = 1'b1;
        bus.o_valid = 1'b1;
        bus.o_idx   = idx;
        bus.o_last  = last_beat;
`ifdef CONST_SEQ_CHECKSUM_EN
        bus.o_data  = cks ? 8'hE2 : rom_data;
`else
        bus.o_data  = rom_data;
`endif
        if (abort) begin
          state_nxt = IDLE;
        end else if (xfer && last_beat) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Index/pass counters and latched pass count; only move on a real transfer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx      <= 3'd0;
      pass_cnt <= '0;
      passes_q <= '0;
`ifdef CONST_SEQ_CHECKSUM_EN
      cks      <= 1'b0;
`endif
    end else if (accept) begin
      idx      <= 3'd0;
      pass_cnt <= '0;
      passes_q <= passes;
`ifdef CONST_SEQ_CHECKSUM_EN
      cks      <= 1'b0;
`endif
    end else if (xfer && !abort) begin
`ifdef CONST_SEQ_CHECKSUM_EN
      if (cks) begin
        cks      <= 1'b0;
        idx      <= 3'd0;
        pass_cnt <= pass_cnt + ONE;
      end else if (idx == 3'd7) begin
        cks <= 1'b1;
      end else begin
        idx <= idx + 3'd1;
      end
`else
      if (idx == 3'd7) begin
        pass_cnt <= pass_cnt + ONE;
      end
      idx <= idx + 3'd1;
`endif
    end
  end

endmodule

// File: tb/tb_const_seq.sv
// Testbench for const_seq. A reference model expands each accepted start
// into the list of beats it should produce; a monitor compares the stream
// against that list, including stall stability and the done pulse.
// Honours CONST_SEQ_CHECKSUM_EN the same way the design does.
module tb_const_seq;

  localparam int PASS_W = 4;
`ifdef CONST_SEQ_CHECKSUM_EN
  localparam int BEATS = 9;
`else
  localparam int BEATS = 8;
`endif

  typedef struct {
    logic [7:0] data;
    logic [2:0] idx;
    logic       last;
  } beat_t;

  logic              clk;
  logic              rst_n;
  logic              start;
  logic              abort;
  logic [PASS_W-1:0] passes;
  logic              busy;
  logic              done;

  const_seq_if bus ();

  const_seq #(.PASS_W(PASS_W)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .abort  (abort),
    .passes (passes),
    .bus    (bus),
    .busy   (busy),
    .done   (done)
  );

  logic [7:0] rom [8];
  beat_t      expq [$];
  int         checks;
  int         passed;
  int         xfers;
  int         ready_mode;
  logic       exp_done;
  logic [7:0] sum8;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) begin
      passed++;
    end else begin
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected stream of one sequence: BEATS beats per pass, last on the very
  // final beat of pass p-1; p=0 never ends, so only nbeats are predicted.
  task automatic pushModel(input int p, input int nbeats);
    int    total;
    int    pass;
    int    pos;
    beat_t b;
    total = (p == 0) ? nbeats : p * BEATS;
    for (int n = 0; n < total; n++) begin
      pass = n / BEATS;
      pos  = n % BEATS;
      if (pos < 8) begin
        b.data = rom[pos];
        b.idx  = pos[2:0];
      end else begin
        b.data = 8'hE2;
        b.idx  = 3'd7;
      end
      b.last = (p != 0) && (pass == p - 1) && (pos == BEATS - 1);
      expq.push_back(b);
    end
  endtask

  // Called at posedge+1 while idle: issue a start and check one-cycle latency
  task automatic applyStimulus(input int p, input int nbeats);
    passes = PASS_W'(p);
    start  = 1'b1;
    pushModel(p, nbeats);
    checkOutput("valid_before_accept", {31'd0, bus.o_valid}, 32'd0);
    @(posedge clk);
    #1;
    start = 1'b0;
    checkOutput("valid_latency", {31'd0, bus.o_valid}, 32'd1);
    checkOutput("busy_in_run", {31'd0, busy}, 32'd1);
    checkOutput("first_idx", {29'd0, bus.o_idx}, 32'd0);
  endtask

  task automatic waitDone(input int budget);
    int n;
    n = 0;
    while (n < budget && !(expq.size() == 0 && !busy && !done)) begin
      @(posedge clk);
      #1;
      n++;
    end
    checkOutput("drain_remaining", expq.size(), 32'd0);
    expq.delete();
  endtask

  // Downstream ready generator: 0 always, 1 toggle, 2 random, 3 stalled
  always begin
    @(posedge clk);
    #1;
    case (ready_mode)
      0: bus.o_ready = 1'b1;
      1: bus.o_ready = ~bus.o_ready;
      2: bus.o_ready = 1'($urandom_range(0, 1));
      default: bus.o_ready = 1'b0;
    endcase
  end

  // Scoreboard monitor: peek while stalled, pop on a transfer
  always @(negedge clk) begin
    if (rst_n) begin
      checkOutput("done_pulse", {31'd0, done}, {31'd0, exp_done});
      exp_done = 1'b0;
      if (bus.o_valid) begin
        if (expq.size() == 0) begin
          checkOutput("unexpected_beat", {31'd0, bus.o_valid}, 32'd0);
        end else begin
          checkOutput("o_data", {24'd0, bus.o_data}, {24'd0, expq[0].data});
          checkOutput("o_idx", {29'd0, bus.o_idx}, {29'd0, expq[0].idx});
          checkOutput("o_last", {31'd0, bus.o_last}, {31'd0, expq[0].last});
          if (bus.o_ready) begin
            sum8  = sum8 + bus.o_data;
            xfers++;
            if (expq[0].last) begin
              exp_done = 1'b1;
            end
            void'(expq.pop_front());
          end
        end
      end
    end
  end

  initial begin
    int         base;
    int         n;
    logic [7:0] exp_sum;

    rom[0] = 8'h01;
    rom[1] = 8'h00;
    rom[2] = 8'(3'b101);
    rom[3] = 8'h65;
    rom[4] = 8'h5A;
    rom[5] = 8'h05;
    rom[6] = 8'(345);
    rom[7] = 8'(-5);

    checks      = 0;
    passed      = 0;
    xfers       = 0;
    exp_done    = 1'b0;
    sum8        = 8'h00;
    ready_mode  = 0;
    rst_n       = 1'b0;
    start       = 1'b0;
    abort       = 1'b0;
    passes      = '0;
    bus.o_ready = 1'b1;

    $display("[TB] reset state");
    #3;
    checkOutput("rst_valid", {31'd0, bus.o_valid}, 32'd0);
    checkOutput("rst_data", {24'd0, bus.o_data}, 32'd0);
    checkOutput("rst_idx", {29'd0, bus.o_idx}, 32'd0);
    checkOutput("rst_last", {31'd0, bus.o_last}, 32'd0);
    checkOutput("rst_busy", {31'd0, busy}, 32'd0);
    checkOutput("rst_done", {31'd0, done}, 32'd0);

    $display("[TB] single pass, ready high, start right after reset release");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    sum8  = 8'h00;
    applyStimulus(1, 0);
    waitDone(100);
`ifdef CONST_SEQ_CHECKSUM_EN
    exp_sum = 8'h00;
`else
    exp_sum = 8'h00;
    for (int i = 0; i < 8; i++) exp_sum = exp_sum + rom[i];
`endif
    checkOutput("beat_sum", {24'd0, sum8}, {24'd0, exp_sum});

    $display("[TB] two passes, ready toggling");
    ready_mode = 1;
    applyStimulus(2, 0);
    waitDone(200);

    $display("[TB] endless run, abort after 20 beats");
    ready_mode = 0;
    base = xfers;
    applyStimulus(0, 40);
    n = 0;
    while (n < 200 && (xfers - base) < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    checkOutput("forever_beats_seen", ((xfers - base) >= 20) ? 32'd1 : 32'd0, 32'd1);
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    expq.delete();
    checkOutput("abort_valid", {31'd0, bus.o_valid}, 32'd0);
    checkOutput("abort_busy", {31'd0, busy}, 32'd0);
    @(posedge clk);
    #1;

    $display("[TB] start with abort in idle, then start while busy");
    passes = 4'd1;
    start  = 1'b1;
    abort  = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    abort = 1'b0;
    checkOutput("start_abort_valid", {31'd0, bus.o_valid}, 32'd0);
    checkOutput("start_abort_busy", {31'd0, busy}, 32'd0);
    ready_mode = 2;
    applyStimulus(2, 0);
    repeat (5) @(posedge clk);
    #1;
    passes = 4'd3;
    start  = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    checkOutput("busy_after_stray_start", {31'd0, busy}, 32'd1);
    waitDone(400);

    $display("[TB] reset while stalled");
    ready_mode = 3;
    applyStimulus(1, 0);
    repeat (3) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    checkOutput("async_rst_valid", {31'd0, bus.o_valid}, 32'd0);
    checkOutput("async_rst_data", {24'd0, bus.o_data}, 32'd0);
    checkOutput("async_rst_idx", {29'd0, bus.o_idx}, 32'd0);
    checkOutput("async_rst_busy", {31'd0, busy}, 32'd0);
    expq.delete();
    exp_done = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("rst_no_done", {31'd0, done}, 32'd0);
    rst_n      = 1'b1;
    ready_mode = 0;
    applyStimulus(1, 0);
    waitDone(100);

    $display("[TB] random sequences");
    for (int k = 0; k < 6; k++) begin
      ready_mode = 2;
      applyStimulus(int'($urandom_range(1, 3)), 0);
      passes = PASS_W'($urandom);
      waitDone(600);
      @(posedge clk);
      #1;
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
